uart_apb_regif: RTL
===================

Name: uart_apb_regif

Overview:
APB3 slave register interface sitting directly upstream of the UART core (uart_top). It drives the core's line configuration (bclk_mode, tlen, parity_en, parity_type) and its TX write strobe/data. It consumes the core's received bytes and error flags into a small RX buffer and sticky status register, and raises a level interrupt. This lets a CPU drive the UART core through memory-mapped accesses.

Parameters:
ADDR_W, 5, APB address width; bits [3:2] select the register, bit 4 set means out of range.
RX_DEPTH, 4, RX buffer entries; power of two, at least 2.
LVL_W, 3, width of the RX level field, equal to log2(RX_DEPTH)+1.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  asynchronous, active-high reset.
psel  in  1  APB select.
penable  in  1  APB access phase.
pwrite  in  1  1 = write, 0 = read.
paddr  in  ADDR_W  byte address; bits [1:0] ignored.
pwdata  in  32  write data.
prdata  out  32  read data; valid in the access phase, 0 when not reading.
pready  out  1  tied high (no wait states).
pslverr  out  1  error response for out-of-range access.
bclk_mode  out  1  CTRL[0] to the UART core.
tlen  out  2  CTRL[2:1] to the UART core.
parity_en  out  1  CTRL[3] to the UART core.
parity_type  out  1  CTRL[4] to the UART core.
tx_wr_en  out  1  one-cycle push strobe to the core's TX FIFO.
tx_wdata  out  8  TX byte, valid with tx_wr_en.
tx_full  in  1  core TX FIFO full.
rx_valid  in  1  one-cycle strobe: rx_data, rx_perr and rx_ferr are new.
rx_data  in  8  received byte.
rx_perr  in  1  parity error for the byte.
rx_ferr  in  1  framing error for the byte.
irq  out  1  level interrupt.

Behaviour:
- Access definitions: access = psel & penable. wr = access & pwrite. rd = access & !pwrite.
- Registers are selected by paddr[3:2]. paddr[ADDR_W-1:4] nonzero is out of range.
- 0x00 DATA, write:
  - tx_full=0: the next cycle has tx_wr_en=1 and tx_wdata=pwdata[7:0] (registered, latency 1).
  - tx_full=1: the write is dropped, no strobe, and STATUS.tx_drop is set.
- 0x00 DATA, read:
  - prdata = {24'b0, head entry} if the buffer is not empty; the head is popped at the access edge.
  - Empty buffer: returns 0, no pop, no error.
- 0x04 CTRL (RW, bits [6:0]):
  - bits: [0] bclk_mode, [2:1] tlen, [3] parity_en, [4] parity_type, [5] rx_ie, [6] err_ie.
  - Reset value 0x06 (8-bit, no parity, x16). Upper bits read 0.
- 0x08 STATUS:
  - [0] rx_ready (buffer not empty, RO).
  - [1] tx_full (live, RO).
  - [2] rx_ovr, [3] perr, [4] ferr, [5] tx_drop: all sticky, write-1-to-clear.
  - [8 +: LVL_W] rx_level (RO).
- 0x0C: reserved; reads 0, writes ignored, pslverr=0.
- Out of range: pslverr=1 in the access phase, no state change, prdata=0.
- RX push: on rx_valid, push rx_data; set perr if rx_perr, and ferr if rx_ferr.
- Buffer full on rx_valid: the byte is discarded, rx_ovr is set, and existing entries are unchanged.
- Same-cycle push and DATA read:
  - Push and pop both occur and the level is unchanged.
  - When full, the push is accepted (no overrun).
  - When empty, the read returns 0 and the push lands.
- Same-cycle set and W1C of a sticky bit: set wins.
- Pointers wrap modulo RX_DEPTH. Level counts 0..RX_DEPTH.
- irq = (rx_ie & rx_ready) | (err_ie & (rx_ovr|perr|ferr|tx_drop)), driven from registers (no combinational path from APB).
- Reset values: prdata=0, pslverr=0, pready=1, tx_wr_en=0, tx_wdata=0, CTRL=0x06, buffer empty, all sticky bits 0, irq=0.
- Reset asserted mid-access aborts the access; a pending tx_wr_en is cancelled.

Decomposition:
- Package uart_regif_pkg holds:
  - register offsets (DATA=0x0, CTRL=0x4, STATUS=0x8);
  - CTRL/STATUS bit-position constants;
  - CTRL_RST=7'h06;
  - a packed struct for the CTRL fields.
- One sub-module, uart_rx_buf: a synchronous FIFO of RX_DEPTH x 8 with push, pop, level, full, empty and the simultaneous push/pop-when-full rule above.

Test Plan:
- Reset, then read CTRL and STATUS -> 0x06 and 0x0; irq=0; pready=1.
- With tx_full=0, write DATA=0x1A5 -> exactly one tx_wr_en pulse with tx_wdata=0xA5 the following cycle. With tx_full=1, write 0x3C -> no pulse, STATUS=0x22; write STATUS 0x20 -> tx_drop cleared.
- Five rx_valid strobes with bytes 0x11..0x15 (RX_DEPTH=4) -> rx_level=4 and rx_ovr=1; four DATA reads return 0x11..0x14, then a read returns 0 and rx_ready=0.
- With the buffer full, assert rx_valid=0x77 in the same cycle as a DATA read -> read returns the head, level stays 4, rx_ovr stays 0, and 0x77 is read last.
- CTRL=0x60, then rx_valid with rx_perr=1 and data 0x55 -> irq=1 and STATUS[3]=1. Write STATUS 0x08 while a new rx_perr strobe arrives -> perr remains 1 (set wins).
- Read and write at paddr=0x10 -> pslverr=1, prdata=0, no register change. Assert rst during a pending TX write -> no tx_wr_en pulse.

Source files
------------

// File: rtl/uart_regif_pkg.sv
// Shared register map, bit positions and CTRL layout for the UART APB register interface.
package uart_regif_pkg;

    localparam logic [3:0] OFF_DATA   = 4'h0;
    localparam logic [3:0] OFF_CTRL   = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;

    localparam logic [1:0] IDX_DATA   = OFF_DATA[3:2];
    localparam logic [1:0] IDX_CTRL   = OFF_CTRL[3:2];
    localparam logic [1:0] IDX_STATUS = OFF_STATUS[3:2];

    localparam int CTRL_W           = 7;
    localparam int CTRL_BCLK_MODE   = 0;
    localparam int CTRL_TLEN_LSB    = 1;
    localparam int CTRL_PARITY_EN   = 3;
    localparam int CTRL_PARITY_TYPE = 4;
    localparam int CTRL_RX_IE       = 5;
    localparam int CTRL_ERR_IE      = 6;

    localparam int ST_RX_READY  = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_RX_OVR    = 2;
    localparam int ST_PERR      = 3;
    localparam int ST_FERR      = 4;
    localparam int ST_TX_DROP   = 5;
    localparam int ST_LEVEL_LSB = 8;

    localparam logic [6:0] CTRL_RST = 7'h06;

    typedef struct packed {
        logic       err_ie;
        logic       rx_ie;
        logic       parity_type;
        logic       parity_en;
        logic [1:0] tlen;
        logic       bclk_mode;
    } ctrl_t;

endpackage

// File: rtl/uart_rx_buf.sv
// RX byte buffer: synchronous FIFO whose pop frees a slot for a same-cycle push when full.
module uart_rx_buf
    import uart_regif_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_apb_regif.sv
// APB3 register front-end for the UART core: line config, TX push, RX buffer, sticky status, irq.
module uart_apb_regif
    import uart_regif_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int RX_DEPTH = 4,
    parameter int LVL_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              bclk_mode,
    output logic [1:0]        tlen,
    output logic              parity_en,
    output logic              parity_type,
    output logic              tx_wr_en,
    output logic [7:0]        tx_wdata,
    input  logic              tx_full,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_perr,
    input  logic              rx_ferr,
    output logic              irq
);

    logic             access;
    logic             wr;
    logic             rd;
    logic             out_of_range;
    logic [1:0]       reg_sel;
    logic             data_wr;
    logic             data_rd;
    logic             ctrl_wr;
    logic             status_wr;
    logic             tx_accept;
    ctrl_t            ctrl_q;
    ctrl_t            ctrl_d;
    logic             rx_ovr_q;
    logic             perr_q;
    logic             ferr_q;
    logic             tx_drop_q;
    logic [7:0]       buf_head;
    logic [LVL_W-1:0] buf_level;
    logic             buf_full;
    logic             buf_empty;
    logic [31:0]      status_word;
    logic             unused_apb;

    assign access       = psel & penable;
    assign wr           = access & pwrite;
    assign rd           = access & ~pwrite;
    assign out_of_range = |paddr[ADDR_W-1:4];
    assign reg_sel      = paddr[3:2];
    assign data_wr      = wr & ~out_of_range & (reg_sel == IDX_DATA);
    assign data_rd      = rd & ~out_of_range & (reg_sel == IDX_DATA);
    assign ctrl_wr      = wr & ~out_of_range & (reg_sel == IDX_CTRL);
    assign status_wr    = wr & ~out_of_range & (reg_sel == IDX_STATUS);
    assign tx_accept    = data_wr & ~tx_full;
    assign unused_apb   = &{1'b0, paddr[1:0], pwdata[31:8]};

    assign pready  = 1'b1;
    assign pslverr = access & out_of_range;

    uart_rx_buf #(
        .DEPTH (RX_DEPTH),
        .LVL_W (LVL_W)
    ) u_rx_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .pop   (data_rd),
        .wdata (rx_data),
        .rdata (buf_head),
        .level (buf_level),
        .full  (buf_full),
        .empty (buf_empty)
    );

    always_comb begin
        ctrl_d             = ctrl_q;
        ctrl_d.bclk_mode   = pwdata[CTRL_BCLK_MODE];
        ctrl_d.tlen        = pwdata[CTRL_TLEN_LSB +: 2];
        ctrl_d.parity_en   = pwdata[CTRL_PARITY_EN];
        ctrl_d.parity_type = pwdata[CTRL_PARITY_TYPE];
        ctrl_d.rx_ie       = pwdata[CTRL_RX_IE];
        ctrl_d.err_ie      = pwdata[CTRL_ERR_IE];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= ctrl_t'(CTRL_RST);
        end else if (ctrl_wr) begin
            ctrl_q <= ctrl_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_en <= 1'b0;
            tx_wdata <= '0;
        end else begin
            tx_wr_en <= tx_accept;
            if (tx_accept) begin
                tx_wdata <= pwdata[7:0];
            end
        end
    end

    // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ovr_q  <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            tx_drop_q <= 1'b0;
        end else begin
            rx_ovr_q  <= (rx_valid & buf_full & ~data_rd)
                       | (rx_ovr_q & ~(status_wr & pwdata[ST_RX_OVR]));
            perr_q    <= (rx_valid & rx_perr)
                       | (perr_q & ~(status_wr & pwdata[ST_PERR]));
            ferr_q    <= (rx_valid & rx_ferr)
                       | (ferr_q & ~(status_wr & pwdata[ST_FERR]));
            tx_drop_q <= (data_wr & tx_full)
                       | (tx_drop_q & ~(status_wr & pwdata[ST_TX_DROP]));
        end
    end

    always_comb begin
        status_word                             = '0;
        status_word[ST_RX_READY]                = ~buf_empty;
        status_word[ST_TX_FULL]                 = tx_full;
        status_word[ST_RX_OVR]                  = rx_ovr_q;
        status_word[ST_PERR]                    = perr_q;
        status_word[ST_FERR]                    = ferr_q;
        status_word[ST_TX_DROP]                 = tx_drop_q;
        status_word[ST_LEVEL_LSB +: LVL_W]      = buf_level;
    end

    always_comb begin
        prdata = '0;
        if (rd && !out_of_range) begin
            case (reg_sel)
                IDX_DATA:   prdata = buf_empty ? 32'h0 : {24'h0, buf_head};
                IDX_CTRL:   prdata = {25'h0, ctrl_q};
                IDX_STATUS: prdata = status_word;
                default:    prdata = '0;
            endcase
        end
    end

    assign bclk_mode   = ctrl_q.bclk_mode;
    assign tlen        = ctrl_q.tlen;
    assign parity_en   = ctrl_q.parity_en;
    assign parity_type = ctrl_q.parity_type;

    assign irq = (ctrl_q.rx_ie & ~buf_empty)
               | (ctrl_q.err_ie & (rx_ovr_q | perr_q | ferr_q | tx_drop_q));

endmodule
